// File: rtl/ysyx_22050243_lsu.sv
// Load/store unit: aligns address/data/mask for the data memory and sign/zero-extends load results.
// Latency: 2 cycles handshake-to-response for memory ops, 1 cycle for errors and no-ops.
// Backpressure: one request in flight; in_ready low until the response is taken by out_ready.
// Optional trace output: define YSYX_22050243_LSU_TRACE_EN.
module ysyx_22050243_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_rdata,
    output logic        out_err,
    output logic        data_r_en,
    output logic        data_w_en,
    output logic [7:0]  data_wmask,
    output logic [63:0] data_addr,
    output logic [63:0] data_w,
    input  logic [63:0] data_r
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      r_state;
    logic        r_load;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic        r_err;

    logic        w_misalign;
    logic        w_err;
    logic        w_access;
    logic [5:0]  w_shamt;
    logic [7:0]  w_mask_base;
    logic [63:0] w_rshift;
    logic [63:0] w_ext;

    always_comb begin
        w_misalign = 1'b0;
        case (in_funct3[1:0])
            2'b01:   w_misalign = in_addr[0];
            2'b10:   w_misalign = |in_addr[1:0];
            2'b11:   w_misalign = |in_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_err = (in_load && in_store) || (in_funct3 == 3'b111)
                 || ((in_funct3 == 3'b110) && in_store) || w_misalign;

    // Memory side is driven only from the request registers so it is stable for the whole ACCESS cycle.
    assign w_access = (r_state == ACCESS);
    assign w_shamt  = {r_addr[2:0], 3'b000};

    always_comb begin
        w_mask_base = 8'h00;
        case (r_funct3[1:0])
            2'b00:   w_mask_base = 8'h01;
            2'b01:   w_mask_base = 8'h03;
            2'b10:   w_mask_base = 8'h0F;
            default: w_mask_base = 8'hFF;
        endcase
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == RESP);
    assign out_rdata  = r_rdata;
    assign out_err    = r_err;
    assign data_r_en  = w_access && r_load;
    assign data_w_en  = w_access && r_store;
    assign data_wmask = data_w_en ? (w_mask_base << r_addr[2:0]) : 8'h00;
    assign data_addr  = {r_addr[63:3], 3'b000};
    assign data_w     = r_wdata << w_shamt;
    assign w_rshift   = data_r >> w_shamt;

    always_comb begin
        w_ext = 64'h0;
        case (r_funct3)
            3'b000:  w_ext = {{56{w_rshift[7]}},  w_rshift[7:0]};
            3'b001:  w_ext = {{48{w_rshift[15]}}, w_rshift[15:0]};
            3'b010:  w_ext = {{32{w_rshift[31]}}, w_rshift[31:0]};
            3'b011:  w_ext = w_rshift;
            3'b100:  w_ext = {56'h0, w_rshift[7:0]};
            3'b101:  w_ext = {48'h0, w_rshift[15:0]};
            3'b110:  w_ext = {32'h0, w_rshift[31:0]};
            default: w_ext = 64'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_load   <= 1'b0;
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 64'h0;
            r_wdata  <= 64'h0;
            r_rdata  <= 64'h0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_load   <= in_load;
                        r_store  <= in_store;
                        r_funct3 <= in_funct3;
                        r_addr   <= in_addr;
                        r_wdata  <= in_wdata;
                        r_rdata  <= 64'h0;
                        r_err    <= w_err;
                        if (w_err || (!in_load && !in_store)) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= ACCESS;
                        end
`ifdef YSYX_22050243_LSU_TRACE_EN
                        if (w_err) begin
                            $display("lsu: misalign addr=0x%h", in_addr);
                        end
`endif
                    end
                end
                ACCESS: begin
                    if (r_load) begin
                        r_rdata <= w_ext;
                    end
                    r_state <= RESP;
`ifdef YSYX_22050243_LSU_TRACE_EN
                    $display("lsu: %s addr=0x%h wdata=0x%h mask=0x%h rdata=0x%h",
                             r_store ? "W" : "R", data_addr, data_w, data_wmask,
                             r_load ? w_ext : 64'h0);
`endif
                end
                RESP: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
